// File: rtl/ldl_reg_hist_pkg.sv
// Shared types and helpers for the event history register.
// The channel mode enum and a saturating increment used by every channel cell.
package ldl_reg_hist_pkg;

  typedef enum logic {
    LEVEL = 1'b0,
    EDGE  = 1'b1
  } hist_mode_e;

  // Counters up to SAT_W bits wide go through the same helper.
  localparam int SAT_W = 32;

  // Increment val, holding at 2^w-1 instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input int unsigned      w);
    logic [SAT_W-1:0] max_v;
    max_v = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
    return (val >= max_v) ? max_v : val + SAT_W'(1);
  endfunction

endpackage

// File: rtl/ldl_reg_hist_cell.sv
// One event channel: event detect, sticky flag and saturating counter.
// A clear and an event in the same cycle leave the channel holding that event.
module ldl_reg_hist_cell
  import ldl_reg_hist_pkg::*;
#(
  parameter int         CNT_W = 4,
  parameter hist_mode_e MODE  = LEVEL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x_i,
  input  logic             clr_i,
  input  logic             rd_clr_i,
  output logic             ev_o,
  output logic             flag_o,
  output logic             flag_nxt_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic             x_d_q;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             ev;

  always_comb begin
    ev = (MODE == EDGE) ? (x_i & ~x_d_q) : x_i;
  end

  // Clear is applied first so an event in the same cycle survives it.
  always_comb begin
    flag_d = flag_q;
    if (clr_i) flag_d = 1'b0;
    if (ev)    flag_d = 1'b1;

    cnt_base = (clr_i || rd_clr_i) ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (ev) cnt_d = CNT_W'(sat_inc(SAT_W'(cnt_base), CNT_W));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_d_q  <= 1'b0;
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      x_d_q  <= x_i;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ev_o       = ev;
  assign flag_o     = flag_q;
  assign flag_nxt_o = flag_d;
  assign cnt_o      = cnt_q;

endmodule

// File: rtl/ldl_reg_hist_cnt.sv
// Multi-channel event history: per-channel flag/counter cells, indexed read
// port with optional read-clear, masked interrupt and first-event capture.
module ldl_reg_hist_cnt #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int EDGE  = 0,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] w1c,
  input  logic [WIDTH-1:0] irq_en,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             rd_clr,
  output logic [WIDTH-1:0] y,
  output logic             rd_ack,
  output logic             rd_flag,
  output logic [CNT_W-1:0] rd_cnt,
  output logic             irq,
  output logic             first_vld,
  output logic [IDX_W-1:0] first_idx
);
  import ldl_reg_hist_pkg::hist_mode_e;

  localparam hist_mode_e MODE = (EDGE != 0) ? ldl_reg_hist_pkg::EDGE
                                            : ldl_reg_hist_pkg::LEVEL;

  logic [WIDTH-1:0] ev_all, flag_all, flag_nxt_all, rd_hit;
  logic [CNT_W-1:0] cnt_all [WIDTH];

  logic             rd_ack_q, rd_flag_q, rd_flag_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             irq_q, irq_d;
  logic             first_vld_q, first_vld_d;
  logic [IDX_W-1:0] first_idx_q, first_idx_d, first_pos;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    ldl_reg_hist_cell #(
      .CNT_W (CNT_W),
      .MODE  (MODE)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .x_i        (x[i]),
      .clr_i      (clr | w1c[i]),
      .rd_clr_i   (rd_req & rd_clr & rd_hit[i]),
      .ev_o       (ev_all[i]),
      .flag_o     (flag_all[i]),
      .flag_nxt_o (flag_nxt_all[i]),
      .cnt_o      (cnt_all[i])
    );
  end

  // Read port: rd_req is a single-cycle request with no back-pressure; each
  // request produces exactly one rd_ack pulse on the following cycle carrying
  // the channel state sampled before that cycle's update. Out-of-range indices
  // hit no channel, so they read zero and clear nothing.
  always_comb begin
    rd_hit    = '0;
    rd_flag_d = 1'b0;
    rd_cnt_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rd_hit[i] = (rd_idx == IDX_W'(i));
      if (rd_hit[i]) begin
        rd_flag_d = flag_all[i];
        rd_cnt_d  = cnt_all[i];
      end
    end
  end

  always_comb begin
    first_pos = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (ev_all[i]) first_pos = IDX_W'(i);
    end

    first_vld_d = first_vld_q & ~clr;
    first_idx_d = first_idx_q;
    if (!first_vld_d && (|ev_all)) begin
      first_vld_d = 1'b1;
      first_idx_d = first_pos;
    end

    irq_d = |(flag_nxt_all & irq_en);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ack_q    <= 1'b0;
      rd_flag_q   <= 1'b0;
      rd_cnt_q    <= '0;
      irq_q       <= 1'b0;
      first_vld_q <= 1'b0;
      first_idx_q <= '0;
    end else begin
      rd_ack_q    <= rd_req;
      if (rd_req) begin
        rd_flag_q <= rd_flag_d;
        rd_cnt_q  <= rd_cnt_d;
      end
      irq_q       <= irq_d;
      first_vld_q <= first_vld_d;
      first_idx_q <= first_idx_d;
    end
  end

  assign y         = flag_all;
  assign rd_ack    = rd_ack_q;
  assign rd_flag   = rd_flag_q;
  assign rd_cnt    = rd_cnt_q;
  assign irq       = irq_q;
  assign first_vld = first_vld_q;
  assign first_idx = first_idx_q;

endmodule

// File: tb/tb_ldl_reg_hist_cnt.sv
// Directed bench for ldl_reg_hist_cnt: a level-mode and an edge-mode instance
// share all inputs; each scenario task checks hand-computed values inline.
module tb_ldl_reg_hist_cnt;

  logic       clk = 1'b0;
  logic       rst_n, clr, rd_req, rd_clr;
  logic [7:0] x, w1c, irq_en;
  logic [3:0] rd_idx;

  logic [7:0] l_y, e_y;
  logic       l_rd_ack, l_rd_flag, l_irq, l_first_vld;
  logic       e_rd_ack, e_rd_flag, e_irq, e_first_vld;
  logic [3:0] l_rd_cnt, e_rd_cnt, l_first_idx, e_first_idx;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_cnt;

  // clock / reset block
  always #5 clk = ~clk;

  ldl_reg_hist_cnt #(.WIDTH(8), .CNT_W(4), .EDGE(0), .IDX_W(4)) dut_lvl (
    .clk(clk), .rst_n(rst_n), .clr(clr), .x(x), .w1c(w1c), .irq_en(irq_en),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_clr(rd_clr),
    .y(l_y), .rd_ack(l_rd_ack), .rd_flag(l_rd_flag), .rd_cnt(l_rd_cnt),
    .irq(l_irq), .first_vld(l_first_vld), .first_idx(l_first_idx)
  );

  ldl_reg_hist_cnt #(.WIDTH(8), .CNT_W(4), .EDGE(1), .IDX_W(4)) dut_edg (
    .clk(clk), .rst_n(rst_n), .clr(clr), .x(x), .w1c(w1c), .irq_en(irq_en),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_clr(rd_clr),
    .y(e_y), .rd_ack(e_rd_ack), .rd_flag(e_rd_flag), .rd_cnt(e_rd_cnt),
    .irq(e_irq), .first_vld(e_first_vld), .first_idx(e_first_idx)
  );

  // driver tasks: inputs change on the falling edge only
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_idle();
    clr = 1'b0; x = '0; w1c = '0; irq_en = '0;
    rd_req = 1'b0; rd_idx = '0; rd_clr = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; step(1); clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; x = 8'hFF;
    step(3);
    total++;
    if ({l_y, l_rd_ack, l_rd_flag, l_rd_cnt, l_irq, l_first_vld, l_first_idx} !== 23'd0) begin
      bad++; $display("FAIL reset_lvl_outputs got=%h exp=0",
        {l_y, l_rd_ack, l_rd_flag, l_rd_cnt, l_irq, l_first_vld, l_first_idx});
    end
    total++;
    if (e_y !== 8'h00) begin bad++; $display("FAIL reset_edg_y got=%h exp=00", e_y); end

    rst_n = 1'b1;
    step(1);
    total++;
    if (l_y !== 8'hFF) begin bad++; $display("FAIL release_lvl_y got=%h exp=ff", l_y); end
    total++;
    if (e_y !== 8'hFF) begin bad++; $display("FAIL release_edg_y got=%h exp=ff", e_y); end
    total++;
    if ({l_first_vld, l_first_idx} !== 5'b1_0000) begin
      bad++; $display("FAIL release_first got=%b exp=10000", {l_first_vld, l_first_idx});
    end

    x = '0; rd_req = 1'b1; rd_idx = 4'd5;
    step(1);
    rd_req = 1'b0;
    total++;
    if ({l_rd_ack, l_rd_flag, l_rd_cnt} !== 6'b1_1_0001) begin
      bad++; $display("FAIL release_lvl_read got=%b exp=110001", {l_rd_ack, l_rd_flag, l_rd_cnt});
    end
    total++;
    if (e_rd_cnt !== 4'd1) begin bad++; $display("FAIL release_edg_cnt got=%0d exp=1", e_rd_cnt); end
    step(1);
    total++;
    if ({l_rd_ack, l_rd_cnt} !== 5'b0_0001) begin
      bad++; $display("FAIL read_hold got=%b exp=00001", {l_rd_ack, l_rd_cnt});
    end
  endtask

  task automatic test_saturation();
    do_clr();
    x = 8'h04;
    step(20);
    x = '0; rd_req = 1'b1; rd_idx = 4'd2;
    exp_q.push_back(4'd15);
    step(1);
    rd_req = 1'b0;
    exp_cnt = exp_q.pop_front();
    total++;
    if ({l_rd_ack, l_rd_flag, l_rd_cnt} !== {2'b11, exp_cnt}) begin
      bad++; $display("FAIL sat_read got=%b exp=%b", {l_rd_ack, l_rd_flag, l_rd_cnt}, {2'b11, exp_cnt});
    end
    total++;
    if (e_rd_cnt !== 4'd1) begin bad++; $display("FAIL sat_edg_cnt got=%0d exp=1", e_rd_cnt); end
    total++;
    if (l_y !== 8'h04) begin bad++; $display("FAIL sat_y got=%h exp=04", l_y); end
  endtask

  task automatic test_edge();
    logic [6:0] pat;
    pat = 7'b1110110;
    do_clr();
    for (int i = 0; i < 7; i++) begin
      x = {7'd0, pat[i]};
      step(1);
    end
    x = '0; rd_req = 1'b1; rd_idx = 4'd0;
    step(1);
    rd_req = 1'b0;
    total++;
    if (e_rd_cnt !== 4'd2) begin bad++; $display("FAIL edge_cnt got=%0d exp=2", e_rd_cnt); end
    total++;
    if (l_rd_cnt !== 4'd5) begin bad++; $display("FAIL edge_lvl_cnt got=%0d exp=5", l_rd_cnt); end
  endtask

  task automatic test_clear_collision();
    do_clr();
    x = 8'h08;
    step(7);
    w1c = 8'h08;
    step(1);
    w1c = '0; x = '0; rd_req = 1'b1; rd_idx = 4'd3;
    exp_q.push_back(4'd1);
    step(1);
    rd_req = 1'b0;
    exp_cnt = exp_q.pop_front();
    total++;
    if ({l_rd_flag, l_rd_cnt} !== {1'b1, exp_cnt}) begin
      bad++; $display("FAIL w1c_collision got=%b exp=%b", {l_rd_flag, l_rd_cnt}, {1'b1, exp_cnt});
    end

    x = 8'h08;
    step(4);
    rd_req = 1'b1; rd_clr = 1'b1;
    step(1);
    total++;
    if ({l_rd_ack, l_rd_cnt} !== 5'b1_0101) begin
      bad++; $display("FAIL rdclr_pre got=%b exp=10101", {l_rd_ack, l_rd_cnt});
    end
    x = '0; rd_clr = 1'b0;
    step(1);
    rd_req = 1'b0;
    total++;
    if ({l_rd_ack, l_rd_flag, l_rd_cnt} !== 6'b1_1_0001) begin
      bad++; $display("FAIL back_to_back_post got=%b exp=110001", {l_rd_ack, l_rd_flag, l_rd_cnt});
    end
  endtask

  task automatic test_first();
    do_clr();
    total++;
    if (l_first_vld !== 1'b0) begin bad++; $display("FAIL first_clr got=%b exp=0", l_first_vld); end
    x = 8'b0010_1000;
    step(1);
    total++;
    if ({l_first_vld, l_first_idx} !== 5'b1_0011) begin
      bad++; $display("FAIL first_cap got=%b exp=10011", {l_first_vld, l_first_idx});
    end
    x = 8'h01; w1c = 8'hFF;
    step(1);
    x = '0; w1c = '0;
    total++;
    if ({l_first_vld, l_first_idx} !== 5'b1_0011) begin
      bad++; $display("FAIL first_hold got=%b exp=10011", {l_first_vld, l_first_idx});
    end
    do_clr();
    total++;
    if (l_first_vld !== 1'b0) begin bad++; $display("FAIL first_reclr got=%b exp=0", l_first_vld); end
    clr = 1'b1; x = 8'h40;
    step(1);
    clr = 1'b0; x = '0;
    total++;
    if ({l_first_vld, l_first_idx} !== 5'b1_0110) begin
      bad++; $display("FAIL first_clr_event got=%b exp=10110", {l_first_vld, l_first_idx});
    end
  endtask

  task automatic test_irq_bounds();
    do_clr();
    irq_en = 8'h01; x = 8'h10;
    step(1);
    total++;
    if (l_irq !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b exp=0", l_irq); end
    x = 8'h01;
    step(1);
    x = '0;
    total++;
    if (l_irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", l_irq); end
    step(1);
    total++;
    if (l_irq !== 1'b1) begin bad++; $display("FAIL irq_sticky got=%b exp=1", l_irq); end
    irq_en = '0;
    step(1);
    total++;
    if (l_irq !== 1'b0) begin bad++; $display("FAIL irq_disable got=%b exp=0", l_irq); end

    rd_req = 1'b1; rd_idx = 4'd9; rd_clr = 1'b1;
    step(1);
    rd_req = 1'b0; rd_clr = 1'b0;
    total++;
    if ({l_rd_ack, l_rd_flag, l_rd_cnt} !== 6'b1_0_0000) begin
      bad++; $display("FAIL read_oob got=%b exp=100000", {l_rd_ack, l_rd_flag, l_rd_cnt});
    end
    rd_req = 1'b1; rd_idx = 4'd0;
    step(1);
    rd_req = 1'b0;
    total++;
    if ({l_rd_flag, l_rd_cnt} !== 5'b1_0001) begin
      bad++; $display("FAIL read_after_oob got=%b exp=10001", {l_rd_flag, l_rd_cnt});
    end
  endtask

  task automatic test_reset_mid();
    x = 8'h0F; rd_req = 1'b1; rd_idx = 4'd0; rst_n = 1'b0;
    step(1);
    rd_req = 1'b0; x = '0;
    total++;
    if ({l_rd_ack, l_y, l_first_vld} !== 10'd0) begin
      bad++; $display("FAIL reset_mid got=%b exp=0", {l_rd_ack, l_y, l_first_vld});
    end
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    step(1);
    test_reset();
    test_saturation();
    test_edge();
    test_clear_collision();
    test_first();
    test_irq_bounds();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldl_reg_hist_cnt.md
# ldl_reg_hist_cnt

Multi-channel event history register: `WIDTH` event inputs each get a sticky flag and a saturating occurrence counter, with selectable level or rising-edge detection. Events are captured per bit, cleared globally or per bit (write-1-to-clear), and read out one channel at a time with optional read-clear. A masked interrupt and a first-event capture serve status/debug blocks that need more than an OR-accumulated history word.

## Interface
- `WIDTH`, 8: number of event channels (≥1).
- `CNT_W`, 4: per-channel counter width (≥1); saturates at 2^CNT_W−1.
- `EDGE`, 0: 0 = level mode (count every cycle `x[i]`=1); 1 = rising-edge mode (count 0→1 transitions).
- `IDX_W`, $clog2(WIDTH) (min 1): width of channel index.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: synchronous reset, active-low (0 is reset).
- `clr` in 1: global clear of flags, counters, first-event capture.
- `x` in WIDTH: event inputs, sampled each rising edge.
- `w1c` in WIDTH: per-bit clear of flag and counter; bit = 1 clears that channel.
- `irq_en` in WIDTH: interrupt enable mask.
- `rd_req` in 1: read request for channel `rd_idx`.
- `rd_idx` in IDX_W: channel to read.
- `rd_clr` in 1: with `rd_req`, clear that channel's counter after read (flag kept).
- `y` out WIDTH: sticky flags.
- `rd_ack` out 1: read response valid, one cycle after `rd_req`.
- `rd_flag` out 1: flag of read channel.
- `rd_cnt` out CNT_W: counter of read channel.
- `irq` out 1: OR of `y & irq_en`.
- `first_vld` out 1: a first event has been captured.
- `first_idx` out IDX_W: lowest channel index firing in the first event cycle.

## Operation
- Event `e[i]`: level mode `x[i]`; edge mode `x[i] & ~x_d[i]`, `x_d` = `x` registered, reset to 0 (input high in first cycle after reset counts as an edge).
- Flag: set on `e[i]`; cleared by `clr` or `w1c[i]`.
- Counter: +1 on `e[i]`, held at max when saturated (no wrap); cleared by `clr`, `w1c[i]`, or read-clear on that channel.
- Priority per channel, same cycle: `rst_n`=0 > event-after-clear. Clear and event together → flag = 1, counter = 1. No event is lost.
- Read: on `rd_req`, next cycle `rd_ack`=1, `rd_flag`/`rd_cnt` = values from before the request cycle's update (pre-clear, pre-event). `rd_idx` ≥ WIDTH → `rd_ack`=1, `rd_flag`=0, `rd_cnt`=0, nothing cleared. `rd_ack` is a one-cycle pulse per request; back-to-back requests give back-to-back acks. Read data holds between acks.
- First event: when `first_vld`=0 and any `e` = 1, `first_vld`←1, `first_idx`← lowest set index. Further events ignored until `clr`. Not affected by `w1c`. `clr` with event same cycle → recaptured from that event.
- `irq` is registered, computed from next-state flags and current `irq_en`.
- `EDGE` and `x_d` are unaffected by `clr`/`w1c`; only `rst_n` resets `x_d`.

## Timing
- Reset values: `y`=0, all counters 0, `x_d`=0, `rd_ack`=0, `rd_flag`=0, `rd_cnt`=0, `irq`=0, `first_vld`=0, `first_idx`=0.
- `x` at edge N → `y`, counter, `irq`, first capture visible after edge N (latency 1).
- `rd_req` at edge N → `rd_ack`/data valid after edge N, for one cycle.
- Reset mid-operation: all state to reset values at that edge; a pending read's ack is dropped.
- `irq_en` change affects `irq` one cycle later.

## Structure
- Package `ldl_reg_hist_pkg`: `hist_mode_e` (LEVEL=0, EDGE=1), helper for saturating increment width.
- Sub-module `ldl_reg_hist_cell`: one channel (edge detect, flag, saturating counter, clear priority); instantiated WIDTH times by generate.
- Top holds read mux/register, first-event priority encoder, irq reduction.

## Test plan
- Reset: hold `rst_n`=0 with `x`=8'hFF → all outputs 0; release, level mode → `y`=8'hFF after one edge, counters 1.
- Saturation: level mode, CNT_W=4, `x[2]`=1 for 20 cycles → read ch 2 returns `rd_cnt`=15, `rd_flag`=1.
- Edge mode: `x[0]` pattern 0,1,1,0,1,1,1 → counter 2; `x[0]` high at reset release → counter 1.
- Clear collision: `w1c[3]`=1 and event on ch 3 same cycle with counter 7 → flag 1, counter 1; `rd_req`+`rd_clr` on ch 3 with event → `rd_cnt`=pre value, counter afterwards 1.
- First event: `x`=8'b0010_1000 first → `first_vld`=1, `first_idx`=3; later `x[0]` → unchanged; `clr` → `first_vld`=0.
- irq/read bounds: `irq_en`=8'h01, event on ch 4 → `irq`=0; event ch 0 → `irq`=1 next cycle; `rd_idx`=9 (WIDTH=8, IDX_W=4 override) → `rd_ack`=1, data 0.
